// File: rtl/parity_frame_pkg.sv
// parity_frame_pkg: FSM state type and saturating counter helper for the parity frame controller
package parity_frame_pkg;
    typedef enum logic [1:0] {IDLE, ACCUM, CHECK} state_t;
    function automatic logic [63:0] sat_inc(input logic [63:0] cnt, input int w);
        logic [63:0] max = {64{1'b1}} >> (64 - w);
        return (cnt >= max) ? cnt : cnt + 64'd1;
    endfunction
endpackage

// File: rtl/parity_frame_ctrl_if.sv
// parity_frame_ctrl_if: symbol and parity valid/ready channels
interface parity_frame_ctrl_if;
    logic       sym_valid;
    logic [1:0] sym_data;
    logic       sym_ready;
    logic       par_valid;
    logic       par_bit;
    logic       par_ready;
    modport master (output sym_valid, sym_data, par_valid, par_bit, input sym_ready, par_ready);
    modport slave  (input sym_valid, sym_data, par_valid, par_bit, output sym_ready, par_ready);
endinterface

// File: rtl/parity_acc.sv
// parity_acc: toggle register folding 2-bit symbols into a running parity; clear beats enable
module parity_acc (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_clr,
    input  logic       i_en,
    input  logic [1:0] i_x_in,
    output logic       o_par
);
    always_ff @(posedge clk or posedge rst)
        if (rst)
            o_par <= 1'b0;
        else if (i_clr)
            o_par <= 1'b0;
        else if (i_en)
            o_par <= o_par ^ i_x_in[1] ^ i_x_in[0];
endmodule

// File: rtl/parity_frame_ctrl.sv
// parity_frame_ctrl: sequences start, FRAME_LEN symbols and one parity bit per frame
// and keeps a saturating count of mismatched frames.
module parity_frame_ctrl
    import parity_frame_pkg::*;
#(
    parameter int FRAME_LEN = 8,
    parameter int CNT_W     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_start,
    input  logic                   i_clr_cnt,
    parity_frame_ctrl_if.slave     bus,
    output logic                   o_busy,
    output logic                   o_run_par,
    output logic                   o_frame_done,
    output logic                   o_frame_err,
    output logic [CNT_W-1:0]       o_err_cnt
);
    localparam int IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    state_t           r_state, w_next;
    logic [IDX_W-1:0] r_idx;
    logic             w_start, w_sym_hs, w_par_hs, w_last, w_mis;
    // Readies come from state alone so no valid-to-ready path exists.
    assign bus.sym_ready = (r_state == ACCUM);
    assign bus.par_ready = (r_state == CHECK);
    assign w_start  = (r_state == IDLE) && i_start;
    assign w_sym_hs = bus.sym_valid && bus.sym_ready;
    assign w_par_hs = bus.par_valid && bus.par_ready;
    assign w_last   = (r_idx == IDX_W'(FRAME_LEN - 1));
    assign w_mis    = (bus.par_bit != o_run_par);
    assign o_busy   = (r_state != IDLE);
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (i_start) w_next = ACCUM;
            ACCUM:   if (w_sym_hs && w_last) w_next = CHECK;
            CHECK:   if (w_par_hs) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_state      <= IDLE;
            r_idx        <= '0;
            o_frame_done <= 1'b0;
            o_frame_err  <= 1'b0;
            o_err_cnt    <= '0;
        end else begin
            r_state      <= w_next;
            o_frame_done <= w_par_hs;
            if (w_start)
                r_idx <= '0;
            else if (w_sym_hs)
                r_idx <= r_idx + IDX_W'(1);
            if (w_start)
                o_frame_err <= 1'b0;
            else if (w_par_hs)
                o_frame_err <= w_mis;
            if (i_clr_cnt)
                o_err_cnt <= '0;
            else if (w_par_hs && w_mis)
                o_err_cnt <= CNT_W'(sat_inc(64'(o_err_cnt), CNT_W));
        end
    parity_acc u_acc (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_start),
        .i_en   (w_sym_hs),
        .i_x_in (bus.sym_data),
        .o_par  (o_run_par)
    );
endmodule

// File: tb/tb_parity_frame_ctrl.sv
// tb_parity_frame_ctrl: table-driven frames with a result scoreboard, plus reset and FRAME_LEN=1 sequences
module tb_parity_frame_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       start_a = 1'b0, clr_a = 1'b0, start_b = 1'b0, clr_b = 1'b0;
    logic       busy_a, rp_a, done_a, err_a;
    logic [1:0] cnt_a;
    logic       busy_b, rp_b, done_b, err_b;
    logic [7:0] cnt_b;

    parity_frame_ctrl_if a ();
    parity_frame_ctrl_if b ();

    parity_frame_ctrl #(.FRAME_LEN(4), .CNT_W(2)) dut_a (
        .clk(clk), .rst(rst), .i_start(start_a), .i_clr_cnt(clr_a), .bus(a),
        .o_busy(busy_a), .o_run_par(rp_a), .o_frame_done(done_a),
        .o_frame_err(err_a), .o_err_cnt(cnt_a)
    );
    parity_frame_ctrl #(.FRAME_LEN(1), .CNT_W(8)) dut_b (
        .clk(clk), .rst(rst), .i_start(start_b), .i_clr_cnt(clr_b), .bus(b),
        .o_busy(busy_b), .o_run_par(rp_b), .o_frame_done(done_b),
        .o_frame_err(err_b), .o_err_cnt(cnt_b)
    );

    typedef struct {
        logic [7:0] syms;
        logic       par;
        logic       stall;
        logic       clr;
        logic       rp;
        logic       err;
        logic [1:0] cnt;
    } vec_t;
    typedef struct {
        logic       err;
        logic [1:0] cnt;
    } exp_t;

    vec_t vt[11];
    exp_t q[$];
    exp_t e;
    int   n_pass = 0;
    int   n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every frame_done pops the result pushed at its parity handshake.
    always @(negedge clk)
        if (done_a) begin
            if (q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_done: got frame_done=1 expected none at %0t", $time);
            end else begin
                e = q.pop_front();
                check("sb_frame_err", err_a, e.err);
                check("sb_err_cnt", cnt_a, e.cnt);
            end
        end

    task automatic run_frame(input vec_t v);
        int n;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        check("start_busy", busy_a, 1);
        check("start_clr_par", rp_a, 0);
        check("start_clr_err", err_a, 0);
        check("par_ready_in_accum", a.par_ready, 0);
        for (int k = 0; k < 4; k++) begin
            if (v.stall) begin
                a.sym_valid = 1'b0;
                a.sym_data  = 2'b11;
                a.par_valid = 1'b1;
                a.par_bit   = ~v.par;
                start_a     = 1'b1;
                tick();
                tick();
                a.par_valid = 1'b0;
                start_a     = 1'b0;
            end
            a.sym_valid = 1'b1;
            a.sym_data  = v.syms[7-2*k -: 2];
            n = 0;
            while (!a.sym_ready && n < 20) begin
                tick();
                n++;
            end
            check("sym_ready", a.sym_ready, 1);
            tick();
        end
        a.sym_valid = 1'b0;
        check("run_par", rp_a, v.rp);
        check("sym_ready_in_check", a.sym_ready, 0);
        if (v.stall) repeat (5) tick();
        a.par_valid = 1'b1;
        a.par_bit   = v.par;
        clr_a       = v.clr;
        q.push_back('{v.err, v.cnt});
        n = 0;
        while (!a.par_ready && n < 20) begin
            tick();
            n++;
        end
        check("par_ready", a.par_ready, 1);
        tick();
        a.par_valid = 1'b0;
        clr_a       = 1'b0;
        check("done_pulse", done_a, 1);
        check("idle_after_par", busy_a, 0);
        tick();
        check("done_one_cycle", done_a, 0);
        tick();
        check("err_hold", err_a, v.err);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vt[0]  = '{8'b01111000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
        vt[1]  = '{8'b01111000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1};
        vt[2]  = '{8'b01111000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1};
        vt[3]  = '{8'b11010100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2};
        vt[4]  = '{8'b01000000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd3};
        vt[5]  = '{8'b10101000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd3};
        vt[6]  = '{8'b00000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3};
        vt[7]  = '{8'b00000000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0};
        vt[8]  = '{8'b11111111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
        vt[9]  = '{8'b01111000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1};
        vt[10] = '{8'b01111000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1};
        a.sym_valid = 1'b0; a.sym_data = 2'b00; a.par_valid = 1'b0; a.par_bit = 1'b0;
        b.sym_valid = 1'b0; b.sym_data = 2'b00; b.par_valid = 1'b0; b.par_bit = 1'b0;
        tick();
        tick();
        check("reset_busy", busy_a, 0);
        check("reset_run_par", rp_a, 0);
        check("reset_done", done_a, 0);
        check("reset_err", err_a, 0);
        check("reset_cnt", cnt_a, 0);
        check("reset_sym_ready", a.sym_ready, 0);
        check("reset_b_busy", busy_b, 0);
        rst = 1'b0;
        tick();
        for (int i = 0; i < 10; i++) run_frame(vt[i]);

        // Abort a frame halfway through with an asynchronous reset.
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        a.sym_valid = 1'b1;
        a.sym_data  = 2'b01;
        tick();
        a.sym_data  = 2'b11;
        tick();
        a.sym_valid = 1'b0;
        check("mid_run_par", rp_a, 1);
        check("mid_busy", busy_a, 1);
        #2 rst = 1'b1;
        #1;
        check("rst_busy", busy_a, 0);
        check("rst_run_par", rp_a, 0);
        check("rst_err", err_a, 0);
        check("rst_cnt", cnt_a, 0);
        check("rst_done", done_a, 0);
        tick();
        rst = 1'b0;
        repeat (3) begin
            tick();
            check("no_done_after_rst", done_a, 0);
        end
        run_frame(vt[10]);

        // FRAME_LEN=1: start ignored in ACCUM, start accepted in the frame_done cycle.
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        check("b_busy", busy_b, 1);
        b.sym_valid = 1'b1;
        b.sym_data  = 2'b10;
        start_b     = 1'b1;
        tick();
        b.sym_valid = 1'b0;
        start_b     = 1'b0;
        check("b_in_check", b.par_ready, 1);
        check("b_sym_ready_off", b.sym_ready, 0);
        check("b_run_par", rp_b, 1);
        b.par_valid = 1'b1;
        b.par_bit   = 1'b1;
        tick();
        b.par_valid = 1'b0;
        check("b_done", done_b, 1);
        check("b_err", err_b, 0);
        check("b_cnt", cnt_b, 0);
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        check("b_restart_busy", busy_b, 1);
        check("b_restart_sym_ready", b.sym_ready, 1);
        check("b_restart_done_low", done_b, 0);
        b.sym_valid = 1'b1;
        b.sym_data  = 2'b00;
        tick();
        b.sym_valid = 1'b0;
        b.par_valid = 1'b1;
        b.par_bit   = 1'b1;
        tick();
        b.par_valid = 1'b0;
        check("b_done2", done_b, 1);
        check("b_err2", err_b, 1);
        check("b_cnt2", cnt_b, 1);

        tick();
        tick();
        check("scoreboard_drained", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
